imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory.
- Accepts a byte stream with a valid/ready handshake, for example from a UART receiver or a debug port, and assembles little-endian 32-bit words.
- Writes those words sequentially into the instruction ROM/RAM word array starting at word 0.
- Holds the CPU core in reset until the whole image has been written, then releases it.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
package imem_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int WORD_W     = 32;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; emits a one-cycle word_valid
// in the cycle after the fourth byte of a word is pushed.
module byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        data,
    output logic [1:0]        lane,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [23:0] partial;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane       <= 2'd0;
            partial    <= 24'd0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= 2'd0;
            end else if (push) begin
                lane <= lane + 2'd1;
                unique case (lane)
                    2'd0: partial[7:0]   <= data;
                    2'd1: partial[15:8]  <= data;
                    2'd2: partial[23:16] <= data;
                    2'd3: begin
                        word       <= {data, partial};
                        word_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed image into instruction memory and holds the core
// in reset until it is loaded. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_ST = CSUM;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              accept;
    logic [15:0]       n_rx;
    logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // Ready is forced low while reset is held, not just after it.
    assign in_ready = reset_n && (state == LEN_LO || state == LEN_HI ||
                                  state == DATA   || state == CSUM);
    assign accept    = in_valid && in_ready;
    assign n_rx      = {in_data, len_lo};
    assign last_word = ({{(16-ADDR_W){1'b0}}, word_idx} == len - 16'd1);
    assign done      = (state == DONE);
    assign error     = (state == ERR);

    byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (accept && state == LEN_HI),
        .push       (accept && state == DATA),
        .data       (in_data),
        .lane       (lane),
        .word_valid (mem_we),
        .word       (mem_wdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LEN_LO;
            len_lo    <= 8'd0;
            len       <= 16'd0;
            word_idx  <= '0;
            mem_waddr <= '0;
            cpu_reset <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            // Release lags done by a cycle so the last write lands first.
            cpu_reset <= !(state == DONE && !reload);
            unique case (state)
                LEN_LO: if (accept) begin
                    len_lo <= in_data;
                    state  <= LEN_HI;
                end
                LEN_HI: if (accept) begin
                    len      <= n_rx;
                    word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum     <= 8'd0;
`endif
                    if (n_rx == 16'd0)
                        state <= END_ST;
                    else if (n_rx > 16'(DEPTH))
                        state <= ERR;
                    else
                        state <= DATA;
                end
                DATA: if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum <= csum ^ in_data;
`endif
                    if (lane == 2'd3) begin
                        mem_waddr <= word_idx;
                        if (last_word)
                            state <= END_ST;
                        else
                            word_idx <= word_idx + 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: if (accept) begin
                    state <= (in_data == csum) ? DONE : ERR;
                end
`endif
                DONE, ERR: if (reload) begin
                    state <= LEN_LO;
                end
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed/random bench for imem_loader against a frame-level reference model.
// Works with and without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          reload = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  pay[$];
    logic [7:0]  csum_mask = 8'd0;
    int          wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(int'(mem_waddr));
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        return {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
    endfunction

    function automatic logic [7:0] csum_of();
        logic [7:0] x = 8'd0;
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int t = 0;
        if (gap_max > 0) tick($urandom_range(gap_max, 0));
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 200) begin
            tick(1);
            t++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready === 1'b1) tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_csum(input int gap_max);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_of() ^ csum_mask, gap_max);
`else
        if (gap_max < 0) tick(1);
`endif
    endtask

    task automatic send_frame(input int n, input int gap_max);
        logic [15:0] nn = 16'(n);
        send_byte(nn[7:0], gap_max);
        send_byte(nn[15:8], gap_max);
        if (n <= DEPTH) begin
            foreach (pay[i]) send_byte(pay[i], gap_max);
            send_csum(gap_max);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick(1);
        reload = 1'b0;
    endtask

    task automatic fill_random(input int nbytes);
        pay.delete();
        for (int i = 0; i < nbytes; i++) pay.push_back(8'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        reset_n = 1'b1;
        tick(1);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // basic single-word load, back-to-back
        pay = '{8'hB3, 8'h03, 8'h53, 8'h00};
        send_frame(1, 0);
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_error", {31'd0, error}, 32'd0);
        check("basic_ready_low", {31'd0, in_ready}, 32'd0);
        check("basic_cpu_rst_hold", {31'd0, cpu_reset}, 32'd1);
        tick(1);
        check("basic_cpu_rst_rel", {31'd0, cpu_reset}, 32'd0);
        check("basic_nwr", wr_addr.size(), 32'd1);
        check("basic_waddr", wr_addr[0], 32'd0);
        check("basic_wdata", wr_data[0], 32'h005303B3);

        pulse_reload();
        check("reload_cpu_rst", {31'd0, cpu_reset}, 32'd1);
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_ready", {31'd0, in_ready}, 32'd1);

        // full image with random gaps and an ignored reload mid-payload
        fill_random(4 * DEPTH);
        wr_addr.delete();
        wr_data.delete();
        send_byte(8'd32, 3);
        send_byte(8'd0, 3);
        for (int i = 0; i < 10; i++) send_byte(pay[i], 3);
        pulse_reload();
        check("data_reload_ignored", {31'd0, in_ready}, 32'd1);
        for (int i = 10; i < 4 * DEPTH; i++) send_byte(pay[i], 3);
        send_csum(3);
        check("full_ready_low", {31'd0, in_ready}, 32'd0);
        check("full_done", {31'd0, done}, 32'd1);
        tick(2);
        check("full_nwr", wr_addr.size(), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < wr_addr.size(); i++) begin
            check("full_waddr", wr_addr[i], 32'(i));
            check("full_wdata", wr_data[i], word_of(i));
        end

        // zero length
        pulse_reload();
        wr_addr.delete();
        pay.delete();
        send_frame(0, 0);
        check("zero_done", {31'd0, done}, 32'd1);
        tick(2);
        check("zero_nwr", wr_addr.size(), 32'd0);
        check("zero_cpu_rst", {31'd0, cpu_reset}, 32'd0);

        // overflow length
        pulse_reload();
        send_frame(DEPTH + 1, 0);
        check("ovf_error", {31'd0, error}, 32'd1);
        check("ovf_done", {31'd0, done}, 32'd0);
        check("ovf_ready", {31'd0, in_ready}, 32'd0);
        tick(2);
        check("ovf_cpu_rst", {31'd0, cpu_reset}, 32'd1);
        check("ovf_nwr", wr_addr.size(), 32'd0);

        // reset mid-load
        pulse_reload();
        fill_random(8);
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_waddr", 32'(mem_waddr), 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_error", {31'd0, error}, 32'd0);
        check("mid_rst_cpu_rst", {31'd0, cpu_reset}, 32'd1);
        #3 reset_n = 1'b1;
        tick(1);
        fill_random(4);
        wr_addr.delete();
        wr_data.delete();
        send_frame(1, 1);
        tick(2);
        check("fresh_nwr", wr_addr.size(), 32'd1);
        check("fresh_waddr", wr_addr[0], 32'd0);
        check("fresh_wdata", wr_data[0], word_of(0));
        check("fresh_done", {31'd0, done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_reload();
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(1, 0);
        check("csum_ok_done", {31'd0, done}, 32'd1);
        pulse_reload();
        wr_data.delete();
        csum_mask = 8'h01;
        send_frame(1, 0);
        csum_mask = 8'h00;
        check("csum_bad_error", {31'd0, error}, 32'd1);
        check("csum_bad_done", {31'd0, done}, 32'd0);
        tick(2);
        check("csum_bad_cpu_rst", {31'd0, cpu_reset}, 32'd1);
        check("csum_bad_word", wr_data[wr_data.size()-1], 32'h44332211);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
